// File: rtl/fifo_ctrl_arbiter_pkg.sv
// Shared constants and state encodings for the FIFO control arbiter,
// its round-robin sub-block and anything that talks to them.
package fifo_ctrl_arbiter_pkg;

   localparam int NUM_FIFO_DEF  = 4;
   localparam int PTR_W         = 3;
   localparam int WORD_SIZE_DEF = 12;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // Index width that stays legal for a single-FIFO configuration.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_ctrl_arbiter_rr.sv
// Combinational round-robin picker: searches last_grant+1 onward, wrapping,
// and returns a one-hot grant plus its index.
module rr_arbiter
   import fifo_ctrl_arbiter_pkg::*;
#(
   parameter int N     = NUM_FIFO_DEF,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int cand;
         cand = (int'(last_grant) + k) % N;
         if (enable && !found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_ctrl_arbiter.sv
// Drains several upstream FIFOs round-robin into one downstream port,
// with threshold loading, backpressure handling and a sticky error state.
module fifo_ctrl_arbiter
   import fifo_ctrl_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int PTR       = PTR_W,
   parameter int NUM_FIFO  = NUM_FIFO_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          init,
   input  logic [PTR-1:0]                full_threshold_in,
   input  logic [PTR-1:0]                empty_threshold_in,
   input  logic [NUM_FIFO-1:0]           fifo_empty,
   input  logic [NUM_FIFO-1:0]           fifo_error,
   input  logic [NUM_FIFO*WORD_SIZE-1:0] fifo_data_out,
   input  logic                          out_almost_full,
   output logic [PTR-1:0]                full_threshold,
   output logic [PTR-1:0]                empty_threshold,
   output logic [NUM_FIFO-1:0]           fifo_rd,
   output logic                          out_wr,
   output logic [WORD_SIZE-1:0]          out_data,
   output logic [2:0]                    state,
   output logic                          idle_out,
   output logic                          error_out
);

   localparam int IDX_W = idx_width(NUM_FIFO);

   state_t           state_q;
   state_t           state_nxt;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_en;

   assign rd_en = (state_q == ST_ACTIVE) && !out_almost_full;

   rr_arbiter #(
      .N     (NUM_FIFO),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (~fifo_empty),
      .last_grant (last_grant),
      .enable     (rd_en),
      .grant      (fifo_rd),
      .grant_idx  (grant_idx)
   );

   // Error beats init, init beats normal traffic; RESET always steps to INIT.
   always_comb begin
      state_nxt = state_q;
      if (state_q != ST_RESET && (|fifo_error)) begin
         state_nxt = ST_ERROR;
      end else begin
         case (state_q)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
               if (init)
                  state_nxt = ST_INIT;
               else if (!(&fifo_empty) && !out_almost_full)
                  state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (init)
                  state_nxt = ST_INIT;
               else if ((&fifo_empty) && !out_wr)
                  state_nxt = ST_IDLE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_RESET;
         full_threshold  <= '0;
         empty_threshold <= '0;
         last_grant      <= IDX_W'(NUM_FIFO - 1);
         out_wr          <= 1'b0;
         rd_idx          <= '0;
         error_out       <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_INIT) begin
            full_threshold  <= full_threshold_in;
            empty_threshold <= empty_threshold_in;
         end
         if (|fifo_rd)
            last_grant <= grant_idx;
         out_wr <= |fifo_rd;
         rd_idx <= grant_idx;
         if (state_nxt == ST_ERROR)
            error_out <= 1'b1;
      end
   end

   // FIFO data arrives one cycle after the strobe, so pick it with the registered index.
   always_comb begin
      out_data = '0;
      if (out_wr)
         out_data = fifo_data_out[int'(rd_idx)*WORD_SIZE +: WORD_SIZE];
   end

   assign state    = state_q;
   assign idle_out = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_ctrl_arbiter.sv
// Directed bench for fifo_ctrl_arbiter: hand-computed expectations checked
// with immediate assertions at each step.
module tb_fifo_ctrl_arbiter;
   import fifo_ctrl_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   logic        init;
   logic [2:0]  full_threshold_in;
   logic [2:0]  empty_threshold_in;
   logic [3:0]  fifo_empty;
   logic [3:0]  fifo_error;
   logic [47:0] fifo_data_out;
   logic        out_almost_full;
   logic [2:0]  full_threshold;
   logic [2:0]  empty_threshold;
   logic [3:0]  fifo_rd;
   logic        out_wr;
   logic [11:0] out_data;
   logic [2:0]  state;
   logic        idle_out;
   logic        error_out;

   int checks = 0;
   int errors = 0;

   fifo_ctrl_arbiter dut (
      .clk                (clk),
      .reset              (reset),
      .init               (init),
      .full_threshold_in  (full_threshold_in),
      .empty_threshold_in (empty_threshold_in),
      .fifo_empty         (fifo_empty),
      .fifo_error         (fifo_error),
      .fifo_data_out      (fifo_data_out),
      .out_almost_full    (out_almost_full),
      .full_threshold     (full_threshold),
      .empty_threshold    (empty_threshold),
      .fifo_rd            (fifo_rd),
      .out_wr             (out_wr),
      .out_data           (out_data),
      .state              (state),
      .idle_out           (idle_out),
      .error_out          (error_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ini, input logic [3:0] emp,
                                input logic [3:0] err, input logic oaf);
      reset           = rst;
      init            = ini;
      fifo_empty      = emp;
      fifo_error      = err;
      out_almost_full = oaf;
      #1;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_state"}, 32'(state), 32'(ST_RESET));
      checkOutput({tag, "_rd"}, 32'(fifo_rd), 32'h0);
      checkOutput({tag, "_wr"}, 32'(out_wr), 32'h0);
      checkOutput({tag, "_data"}, 32'(out_data), 32'h0);
      checkOutput({tag, "_err"}, 32'(error_out), 32'h0);
      checkOutput({tag, "_fth"}, 32'(full_threshold), 32'h0);
      checkOutput({tag, "_eth"}, 32'(empty_threshold), 32'h0);
      checkOutput({tag, "_idle"}, 32'(idle_out), 32'h0);
   endtask

   initial begin
      fifo_data_out      = {12'h444, 12'h333, 12'h222, 12'h111};
      full_threshold_in  = 3'd6;
      empty_threshold_in = 3'd2;
      applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
      @(negedge clk);
      stepCycle();
      checkAllZero("reset");

      // Threshold load: states 0,1,1,2
      applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
      checkOutput("seq0", 32'(state), 32'd0);
      stepCycle();
      checkOutput("seq1", 32'(state), 32'd1);
      stepCycle();
      checkOutput("seq2", 32'(state), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("seq3", 32'(state), 32'd2);
      checkOutput("idle", 32'(idle_out), 32'd1);
      checkOutput("fth", 32'(full_threshold), 32'd6);
      checkOutput("eth", 32'(empty_threshold), 32'd2);

      // FIFOs 0 and 2 non-empty
      applyStimulus(1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0);
      checkOutput("idle_rd", 32'(fifo_rd), 32'h0);
      stepCycle();
      checkOutput("act_state", 32'(state), 32'd3);
      checkOutput("act_wr0", 32'(out_wr), 32'd0);
      checkOutput("rd_a0", 32'(fifo_rd), 32'b0001);
      stepCycle();
      checkOutput("wr_a0", 32'(out_wr), 32'd1);
      checkOutput("data_a0", 32'(out_data), 32'h111);
      checkOutput("rd_a1", 32'(fifo_rd), 32'b0100);
      stepCycle();
      checkOutput("data_a1", 32'(out_data), 32'h333);
      checkOutput("rd_a2", 32'(fifo_rd), 32'b0001);
      stepCycle();
      checkOutput("wr_a2", 32'(out_wr), 32'd1);
      checkOutput("data_a2", 32'(out_data), 32'h111);

      // Only FIFO 3, then all four: grants 3 then 0,1,2,3,0
      applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 1'b0);
      checkOutput("rd_b3", 32'(fifo_rd), 32'b1000);
      stepCycle();
      checkOutput("data_b3", 32'(out_data), 32'h444);
      applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      checkOutput("rd_c0", 32'(fifo_rd), 32'b0001);
      stepCycle();
      checkOutput("data_c0", 32'(out_data), 32'h111);
      checkOutput("rd_c1", 32'(fifo_rd), 32'b0010);
      stepCycle();
      checkOutput("data_c1", 32'(out_data), 32'h222);
      checkOutput("rd_c2", 32'(fifo_rd), 32'b0100);
      stepCycle();
      checkOutput("data_c2", 32'(out_data), 32'h333);
      checkOutput("rd_c3", 32'(fifo_rd), 32'b1000);
      stepCycle();
      checkOutput("data_c3", 32'(out_data), 32'h444);
      checkOutput("rd_c4", 32'(fifo_rd), 32'b0001);
      stepCycle();

      // Backpressure rises while the fifth read is in flight
      applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
      checkOutput("bp_rd", 32'(fifo_rd), 32'h0);
      checkOutput("bp_wr", 32'(out_wr), 32'd1);
      checkOutput("bp_data", 32'(out_data), 32'h111);
      stepCycle();
      checkOutput("bp_wr_done", 32'(out_wr), 32'd0);
      checkOutput("bp_state", 32'(state), 32'd3);
      checkOutput("bp_rd2", 32'(fifo_rd), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      checkOutput("resume_rd", 32'(fifo_rd), 32'b0010);
      stepCycle();
      checkOutput("resume_data", 32'(out_data), 32'h222);

      // Error together with init: error wins and sticks
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0);
      stepCycle();
      checkOutput("err_state", 32'(state), 32'd4);
      checkOutput("err_flag", 32'(error_out), 32'd1);
      checkOutput("err_rd", 32'(fifo_rd), 32'h0);
      checkOutput("err_idle", 32'(idle_out), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("err_hold", 32'(state), 32'd4);
      checkOutput("err_hold_flag", 32'(error_out), 32'd1);
      checkOutput("err_hold_rd", 32'(fifo_rd), 32'h0);
      applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
      stepCycle();
      checkAllZero("err_reset");

      // Back to ACTIVE, then reset while a read is being issued
      full_threshold_in  = 3'd5;
      empty_threshold_in = 3'd1;
      applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("re_idle", 32'(state), 32'd2);
      checkOutput("re_fth", 32'(full_threshold), 32'd5);
      checkOutput("re_eth", 32'(empty_threshold), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'b1110, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("re_rd", 32'(fifo_rd), 32'b0001);
      applyStimulus(1'b1, 1'b0, 4'b1110, 4'b0000, 1'b0);
      stepCycle();
      checkAllZero("abort");
      stepCycle();
      checkOutput("abort_wr2", 32'(out_wr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
